// File: rtl/cpu4_pkg.sv
// Shared definitions for the 4-bit CPU: opcodes, sequencer states, ALU op codes, decoded controls.
// Pure declarations, no logic; imported by the fetch/decode block and the ALU.
// No flow control: constants and types only.
package cpu4_pkg;

    localparam int PCW_DEF = 4;
    localparam int IW_DEF  = 8;
    localparam int OPW_DEF = 4;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_SUBI = 4'h3;
    localparam logic [3:0] OP_JMP0 = 4'h4;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'b00,
        ST_DECODE = 2'b01,
        ST_EXEC   = 2'b10,
        ST_HALT   = 2'b11
    } state_t;

    typedef struct packed {
        logic       acc_we;
        logic [1:0] alu_op;
        logic       set_pc;
        logic       is_halt;
    } ctrl_t;

endpackage

// File: rtl/instr_decoder.sv
// Opcode -> datapath control decode; unknown opcodes fall back to NOP controls.
// Latency: combinational, zero cycles.
// No flow control: the sequencer registers the result when it needs it.
module instr_decoder
    import cpu4_pkg::*;
#(
    parameter int OPW = OPW_DEF
) (
    input  logic [OPW-1:0] opcode,
    output ctrl_t          ctrl
);

    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = ALU_PASS;
        case (opcode)
            OP_LDI: begin
                ctrl.acc_we = 1'b1;
                ctrl.alu_op = ALU_PASS;
            end
            OP_ADDI: begin
                ctrl.acc_we = 1'b1;
                ctrl.alu_op = ALU_ADD;
            end
            OP_SUBI: begin
                ctrl.acc_we = 1'b1;
                ctrl.alu_op = ALU_SUB;
            end
            OP_JMP0: ctrl.set_pc  = 1'b1;
            OP_HLT:  ctrl.is_halt = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode sequencer: FETCH -> DECODE -> EXEC, one instruction per three cycles; HLT parks in HALT.
// Latency: IR loads on the FETCH edge, controls (incl. pc_step) are live for exactly the EXEC cycle.
// No backpressure: the PC stage only advances when pc_step is high, so it is paced by this block.
module fetch_decode
    import cpu4_pkg::*;
#(
    parameter int PCW = PCW_DEF,
    parameter int IW  = IW_DEF,
    parameter int OPW = OPW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PCW-1:0]    PC_CURR,
    input  logic [IW-1:0]     INSTR_IN,
    output logic [PCW-1:0]    IMEM_ADDR,
    output logic [IW-1:0]     IR,
    output logic [IW-OPW-1:0] IMM,
    output logic              acc_we,
    output logic [1:0]        alu_op,
    output logic              pc_step,
    output logic              set_pc,
    output logic              halted,
    output logic [1:0]        state
);

    state_t         state_q;
    logic [IW-1:0]  ir_q;
    ctrl_t          dec;

    instr_decoder #(.OPW(OPW)) u_dec (
        .opcode (ir_q[IW-1:IW-OPW]),
        .ctrl   (dec)
    );

    assign IMEM_ADDR = PC_CURR;
    assign IR        = ir_q;
    assign IMM       = ir_q[IW-OPW-1:0];
    assign state     = state_q;

    // Controls default low every edge, so they only survive the single EXEC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            ir_q    <= '0;
            acc_we  <= 1'b0;
            alu_op  <= ALU_PASS;
            pc_step <= 1'b0;
            set_pc  <= 1'b0;
            halted  <= 1'b0;
        end else begin
            acc_we  <= 1'b0;
            alu_op  <= ALU_PASS;
            pc_step <= 1'b0;
            set_pc  <= 1'b0;
            case (state_q)
                ST_FETCH: begin
                    ir_q    <= INSTR_IN;
                    state_q <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (dec.is_halt) begin
                        halted  <= 1'b1;
                        state_q <= ST_HALT;
                    end else begin
                        acc_we  <= dec.acc_we;
                        alu_op  <= dec.alu_op;
                        set_pc  <= dec.set_pc;
                        pc_step <= 1'b1;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC:  state_q <= ST_FETCH;
                ST_HALT:  state_q <= ST_HALT;
                default:  state_q <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_decode.sv
// Scoreboarded bench for fetch_decode: bench-side ROM and PC stage, expected EXEC cycles queued per test.
// Each pc_step pulse pops one expectation; controls outside EXEC must be idle.
module tb_fetch_decode;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] PC_CURR;
    logic [7:0] INSTR_IN;
    logic [3:0] IMEM_ADDR;
    logic [7:0] IR;
    logic [3:0] IMM;
    logic       acc_we;
    logic [1:0] alu_op;
    logic       pc_step;
    logic       set_pc;
    logic       halted;
    logic [1:0] state;

    fetch_decode dut (
        .clk       (clk),
        .rst       (rst),
        .PC_CURR   (PC_CURR),
        .INSTR_IN  (INSTR_IN),
        .IMEM_ADDR (IMEM_ADDR),
        .IR        (IR),
        .IMM       (IMM),
        .acc_we    (acc_we),
        .alu_op    (alu_op),
        .pc_step   (pc_step),
        .set_pc    (set_pc),
        .halted    (halted),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] pc;
        logic       acc_we;
        logic [1:0] alu_op;
        logic       set_pc;
        logic [3:0] imm;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] rom [16];
    logic [3:0] pc_init = 4'd0;
    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         exp_halt_cyc = 1000;
    bit         mon_en = 1'b0;

    // Bench-side PC stage and combinational ROM.
    always @(posedge clk or posedge rst) begin
        if (rst)          PC_CURR <= pc_init;
        else if (pc_step) PC_CURR <= set_pc ? 4'd0 : PC_CURR + 4'd1;
    end
    assign INSTR_IN = rom[IMEM_ADDR];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic exp_push(input int c, input logic [3:0] pc, input logic we,
                            input logic [1:0] op, input logic sp, input logic [3:0] imm);
        exp_t e;
        e.cyc = c; e.pc = pc; e.acc_we = we; e.alu_op = op; e.set_pc = sp; e.imm = imm;
        sb_q.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            cyc++;
            chk("no_x", 32'($isunknown({IR, IMM, acc_we, alu_op, pc_step, set_pc, halted, state, IMEM_ADDR})), 0);
            chk("imem_addr", 32'(IMEM_ADDR), 32'(PC_CURR));
            chk("halted", 32'(halted), 32'(cyc >= exp_halt_cyc));
            if (pc_step) begin
                if (sb_q.size() == 0) begin
                    chk("unexp_step", 32'(pc_step), 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("exec_cyc", 32'(cyc), 32'(e.cyc));
                    chk("exec_pc", 32'(PC_CURR), 32'(e.pc));
                    chk("exec_state", 32'(state), 32'd2);
                    chk("acc_we", 32'(acc_we), 32'(e.acc_we));
                    chk("alu_op", 32'(alu_op), 32'(e.alu_op));
                    chk("set_pc", 32'(set_pc), 32'(e.set_pc));
                    chk("imm", 32'(IMM), 32'(e.imm));
                end
            end else begin
                chk("idle_ctl", 32'({acc_we, set_pc, alu_op}), 0);
            end
        end
    end

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_outs", 32'({acc_we, alu_op, pc_step, set_pc, halted}), 0);
        chk("rst_ir", 32'(IR), 0);
        chk("rst_state", 32'(state), 0);
        exp_halt_cyc = 1000;
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        cyc = 1;
        mon_en = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drained(input string tag);
        chk(tag, 32'(sb_q.size()), 0);
    endtask

    initial begin
        clear_rom();

        // LDI 5, ADDI 3, SUBI 1
        rom[0] = 8'h15; rom[1] = 8'h23; rom[2] = 8'h31;
        do_reset();
        exp_push(3, 4'd0, 1'b1, 2'b00, 1'b0, 4'd5);
        exp_push(6, 4'd1, 1'b1, 2'b01, 1'b0, 4'd3);
        exp_push(9, 4'd2, 1'b1, 2'b10, 1'b0, 4'd1);
        run(9);
        drained("seq_drain");

        // JMP0 at PC=7, then LDI 2 from PC=0
        clear_rom();
        rom[7] = 8'h40; rom[0] = 8'h12;
        pc_init = 4'd7;
        do_reset();
        exp_push(3, 4'd7, 1'b0, 2'b00, 1'b1, 4'd0);
        exp_push(6, 4'd0, 1'b1, 2'b00, 1'b0, 4'd2);
        run(6);
        drained("jmp_drain");

        // Undefined opcode behaves as NOP
        clear_rom();
        rom[0] = 8'h9A; rom[1] = 8'h00;
        pc_init = 4'd0;
        do_reset();
        exp_push(3, 4'd0, 1'b0, 2'b00, 1'b0, 4'hA);
        exp_push(6, 4'd1, 1'b0, 2'b00, 1'b0, 4'h0);
        run(6);
        drained("undef_drain");

        // NOP at PC=15 wraps to LDI 5 at PC=0
        clear_rom();
        rom[15] = 8'h00; rom[0] = 8'h15;
        pc_init = 4'd15;
        do_reset();
        exp_push(3, 4'd15, 1'b0, 2'b00, 1'b0, 4'd0);
        exp_push(6, 4'd0, 1'b1, 2'b00, 1'b0, 4'd5);
        run(6);
        drained("wrap_drain");

        // HLT at PC=2: sticky, ignores ROM changes, no pc_step
        clear_rom();
        rom[2] = 8'hF0;
        pc_init = 4'd0;
        do_reset();
        exp_halt_cyc = 9;
        exp_push(3, 4'd0, 1'b0, 2'b00, 1'b0, 4'd0);
        exp_push(6, 4'd1, 1'b0, 2'b00, 1'b0, 4'd0);
        run(12);
        rom[2] = 8'h15;
        run(20);
        drained("halt_drain");
        chk("halt_ir", 32'(IR), 32'h0000_00F0);
        chk("halt_state", 32'(state), 32'd3);
        chk("halt_pc", 32'(PC_CURR), 32'd2);

        // Asynchronous reset in the middle of an ADDI EXEC cycle
        clear_rom();
        rom[0] = 8'h23;
        do_reset();
        exp_push(3, 4'd0, 1'b1, 2'b01, 1'b0, 4'd3);
        run(2);
        chk("pre_rst_step", 32'(pc_step), 1);
        mon_en = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("async_outs", 32'({acc_we, alu_op, pc_step, set_pc, halted}), 0);
        chk("async_ir", 32'(IR), 0);
        chk("async_state", 32'(state), 0);
        drained("async_drain");
        rom[0] = 8'h37;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ir", 32'(IR), 0);
        @(posedge clk);
        #1;
        chk("first_load_ir", 32'(IR), 32'h0000_0037);
        chk("first_load_state", 32'(state), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
